// File: rtl/framebuffer_read_arbiter.sv
// ----------------------------------------------------------------------------
// framebuffer_read_arbiter
//
// Purpose:
//   Single-port 16-bit frame buffer shared by N_CHANNELS serializer read
//   channels and one upstream pixel-loader write port. One memory access is
//   performed at a time. A pending write always goes first. Reads are granted
//   round-robin. Each completed read returns its word on the shared read_data
//   bus, together with a one-cycle finished strobe for the channel that asked.
//
// Ports:
//   clk                      system clock
//   rst                      synchronous, active-high reset
//   read_address_bus         channel k read address in bits [k*AW +: AW]
//   read_strobe_bus          level read request per channel; held high until
//                            that channel's finished strobe
//   read_data                returned word; valid while a finished bit is high
//   read_finished_strobe_bus one-cycle completion pulse per channel
//   write_address            write word address
//   write_data               write word
//   write_strobe             one-cycle write request
//   write_ready              high when a write can be accepted
//   addr_error               sticky error flag: out-of-range access or a
//                            write offered while write_ready was low
// ----------------------------------------------------------------------------
module framebuffer_read_arbiter #(
  parameter int N_CHANNELS        = 4,
  parameter int WORD_COUNT        = 1344,
  parameter int ADDRESS_BUS_WIDTH = 12
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_CHANNELS*ADDRESS_BUS_WIDTH-1:0] read_address_bus,
  input  logic [N_CHANNELS-1:0]                   read_strobe_bus,
  output logic [15:0]                             read_data,
  output logic [N_CHANNELS-1:0]                   read_finished_strobe_bus,
  input  logic [ADDRESS_BUS_WIDTH-1:0]            write_address,
  input  logic [15:0]                             write_data,
  input  logic                                    write_strobe,
  output logic                                    write_ready,
  output logic                                    addr_error
);

  localparam int AW     = ADDRESS_BUS_WIDTH;
  localparam int CH_W   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int MEM_AW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  // One extra bit so that WORD_COUNT == 2**AW is still representable.
  localparam logic [AW:0] WORD_LIMIT = (AW+1)'(WORD_COUNT);
  localparam logic [CH_W:0] N_CH_W   = (CH_W+1)'(N_CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE       = 2'd1,
    READ_ISSUE  = 2'd2,
    READ_RETURN = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                  state_q,      state_d;
  logic [CH_W-1:0]         rr_ptr_q,     rr_ptr_d;
  logic [CH_W-1:0]         grant_q,      grant_d;
  logic [AW-1:0]           rd_addr_q,    rd_addr_d;
  logic [15:0]             read_data_q,  read_data_d;
  logic [N_CHANNELS-1:0]   fin_q,        fin_d;
  logic [N_CHANNELS-1:0]   fin_prev_q,   fin_prev_d;
  logic                    wr_pending_q, wr_pending_d;
  logic [AW-1:0]           wr_addr_q,    wr_addr_d;
  logic [15:0]             wr_data_q,    wr_data_d;
  logic                    addr_error_q, addr_error_d;

  // Memory read register (block RAM output register, not reset).
  logic [15:0]             mem_rd_q;

  // --------------------------------------------------------------------------
  // Per-channel address unpacking
  // --------------------------------------------------------------------------
  logic [AW-1:0] ch_addr [N_CHANNELS];

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch_addr
    assign ch_addr[gi] = read_address_bus[gi*AW +: AW];
  end

  // --------------------------------------------------------------------------
  // Round-robin request selection
  // --------------------------------------------------------------------------
  // A channel whose finished strobe is high now, or was high last cycle, is
  // masked: its request flop may not have dropped yet and must not be taken
  // as a fresh request.
  logic [N_CHANNELS-1:0]   req_eligible;
  logic [2*N_CHANNELS-1:0] req_dbl;
  logic [N_CHANNELS-1:0]   req_rot;
  logic [CH_W:0]           cand_sum [N_CHANNELS];
  logic [CH_W-1:0]         cand_idx [N_CHANNELS];
  logic                    grant_found;
  logic [CH_W-1:0]         grant_idx;

  assign req_eligible = read_strobe_bus & ~(fin_q | fin_prev_q);

  // Doubling the request vector turns the cyclic search into a linear one:
  // req_rot[i] is the request of channel (rr_ptr + i) mod N_CHANNELS.
  assign req_dbl = {req_eligible, req_eligible};
  assign req_rot = req_dbl[rr_ptr_q +: N_CHANNELS];

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, rr_ptr_q} + (CH_W+1)'(gi);
    assign cand_idx[gi] = (cand_sum[gi] >= N_CH_W) ? CH_W'(cand_sum[gi] - N_CH_W)
                                                    : CH_W'(cand_sum[gi]);
  end

  // Lowest rotated position wins; scanning downwards lets the last hit stand.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Range checks
  // --------------------------------------------------------------------------
  logic wr_in_range;
  logic rd_in_range;

  assign wr_in_range = ({1'b0, wr_addr_q} < WORD_LIMIT);
  assign rd_in_range = ({1'b0, rd_addr_q} < WORD_LIMIT);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    rd_addr_d    = rd_addr_q;
    read_data_d  = read_data_q;
    fin_d        = '0;
    fin_prev_d   = fin_q;
    wr_pending_d = wr_pending_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    addr_error_d = addr_error_q;

    // Write capture runs independently of the FSM. A pending write is only
    // seen by IDLE one cycle later, so a read granted in the same cycle as
    // the capture goes first and the write follows it.
    if (write_strobe) begin
      if (!wr_pending_q) begin
        wr_pending_d = 1'b1;
        wr_addr_d    = write_address;
        wr_data_d    = write_data;
      end else begin
        addr_error_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (wr_pending_q) begin
          state_d = WRITE;
        end else if (grant_found) begin
          grant_d   = grant_idx;
          rd_addr_d = ch_addr[grant_idx];
          state_d   = READ_ISSUE;
        end
      end

      WRITE: begin
        // The memory write itself happens in the RAM process below.
        if (!wr_in_range) begin
          addr_error_d = 1'b1;
        end
        wr_pending_d = 1'b0;
        state_d      = IDLE;
      end

      READ_ISSUE: begin
        state_d = READ_RETURN;
      end

      READ_RETURN: begin
        if (rd_in_range) begin
          read_data_d = mem_rd_q;
        end else begin
          read_data_d  = '0;
          addr_error_d = 1'b1;
        end
        fin_d[grant_q] = 1'b1;
        rr_ptr_d       = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // Reset drops any in-flight read without a finished strobe; the requester
  // keeps its strobe high and is picked up again after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      rd_addr_q    <= '0;
      read_data_q  <= '0;
      fin_q        <= '0;
      fin_prev_q   <= '0;
      wr_pending_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      rd_addr_q    <= rd_addr_d;
      read_data_q  <= read_data_d;
      fin_q        <= fin_d;
      fin_prev_q   <= fin_prev_d;
      wr_pending_q <= wr_pending_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      addr_error_q <= addr_error_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame buffer RAM: single port, registered read, contents not reset.
  // Out-of-range addresses never touch the array.
  // --------------------------------------------------------------------------
  logic [15:0] mem [WORD_COUNT];

  always_ff @(posedge clk) begin
    if (state_q == WRITE && wr_in_range) begin
      mem[wr_addr_q[MEM_AW-1:0]] <= wr_data_q;
    end
    if (state_q == READ_ISSUE && rd_in_range) begin
      mem_rd_q <= mem[rd_addr_q[MEM_AW-1:0]];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign read_data                = read_data_q;
  assign read_finished_strobe_bus = fin_q;
  assign write_ready              = ~wr_pending_q;
  assign addr_error               = addr_error_q;

endmodule

// File: tb/tb_framebuffer_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_framebuffer_read_arbiter
//
// Directed testbench for framebuffer_read_arbiter with 4 channels, 1344 words
// and 12-bit addresses. Inputs change 1 time unit after the rising edge, and
// outputs are sampled at that same point. Expected values are hand-derived
// constants.
// ----------------------------------------------------------------------------
module tb_framebuffer_read_arbiter;

  localparam int N  = 4;
  localparam int WC = 1344;
  localparam int AW = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*AW-1:0]   read_address_bus;
  logic [N-1:0]      read_strobe_bus;
  logic [15:0]       read_data;
  logic [N-1:0]      read_finished_strobe_bus;
  logic [AW-1:0]     write_address;
  logic [15:0]       write_data;
  logic              write_strobe;
  logic              write_ready;
  logic              addr_error;

  int checks = 0;
  int errors = 0;

  framebuffer_read_arbiter #(
    .N_CHANNELS        (N),
    .WORD_COUNT        (WC),
    .ADDRESS_BUS_WIDTH (AW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .read_address_bus         (read_address_bus),
    .read_strobe_bus          (read_strobe_bus),
    .read_data                (read_data),
    .read_finished_strobe_bus (read_finished_strobe_bus),
    .write_address            (write_address),
    .write_data               (write_data),
    .write_strobe             (write_strobe),
    .write_ready              (write_ready),
    .addr_error               (addr_error)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Issues one write from IDLE and returns once it has landed (ready again).
  task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d);
    write_address = a;
    write_data    = d;
    write_strobe  = 1'b1;
    tick();
    write_strobe  = 1'b0;
    tick();
    tick();
    $display("write addr=%0d data=0x%04h", a, d);
  endtask

  // Raises one channel's request and waits (bounded) for any finished strobe.
  // lat is the number of edges from raising the request to the pulse, or -1.
  task automatic do_read(input int ch, input logic [AW-1:0] a,
                         output logic [15:0] data, output logic [N-1:0] fvec,
                         output int lat);
    read_address_bus[ch*AW +: AW] = a;
    read_strobe_bus[ch] = 1'b1;
    lat  = -1;
    fvec = '0;
    data = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (read_finished_strobe_bus != '0) begin
        lat  = i;
        fvec = read_finished_strobe_bus;
        data = read_data;
        break;
      end
    end
    read_strobe_bus[ch] = 1'b0;
    tick();
    tick();
    $display("read ch%0d addr=%0d data=0x%04h fin=%b lat=%0d", ch, a, data, fvec, lat);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (read_data !== 16'h0) begin errors++; $display("FAIL reset_read_data got=%h exp=0000", read_data); end
    checks++; if (read_finished_strobe_bus !== 4'b0) begin errors++; $display("FAIL reset_fin got=%b exp=0000", read_finished_strobe_bus); end
    checks++; if (write_ready !== 1'b1) begin errors++; $display("FAIL reset_write_ready got=%b exp=1", write_ready); end
    checks++; if (addr_error !== 1'b0) begin errors++; $display("FAIL reset_addr_error got=%b exp=0", addr_error); end
    rst = 1'b0;
    tick();
    checks++; if (write_ready !== 1'b1) begin errors++; $display("FAIL idle_write_ready got=%b exp=1", write_ready); end
    $display("reset done");
  endtask

  task automatic test_write_read();
    write_address = 12'd5;
    write_data    = 16'hA5C3;
    write_strobe  = 1'b1;
    tick();
    write_strobe  = 1'b0;
    checks++; if (write_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_low1 got=%b exp=0", write_ready); end
    tick();
    checks++; if (write_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_low2 got=%b exp=0", write_ready); end
    tick();
    checks++; if (write_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_back got=%b exp=1", write_ready); end
    $display("write addr=5 data=0xa5c3");

    read_address_bus[0 +: AW] = 12'd5;
    read_strobe_bus[0] = 1'b1;
    tick();
    checks++; if (read_finished_strobe_bus !== 4'b0) begin errors++; $display("FAIL fin_early1 got=%b exp=0000", read_finished_strobe_bus); end
    tick();
    checks++; if (read_finished_strobe_bus !== 4'b0) begin errors++; $display("FAIL fin_early2 got=%b exp=0000", read_finished_strobe_bus); end
    tick();
    checks++; if (read_finished_strobe_bus !== 4'b0001) begin errors++; $display("FAIL fin_ch0 got=%b exp=0001", read_finished_strobe_bus); end
    checks++; if (read_data !== 16'hA5C3) begin errors++; $display("FAIL rd_data_5 got=%h exp=a5c3", read_data); end
    read_strobe_bus[0] = 1'b0;
    tick();
    checks++; if (read_finished_strobe_bus !== 4'b0) begin errors++; $display("FAIL fin_one_cycle got=%b exp=0000", read_finished_strobe_bus); end
    checks++; if (read_data !== 16'hA5C3) begin errors++; $display("FAIL rd_data_hold got=%h exp=a5c3", read_data); end
    tick();
    $display("read ch0 addr=5 data=0x%04h", read_data);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] fv;
    int           lat;
    int           exp_ch;
    apply_reset();
    for (int k = 0; k < N; k++) do_write(AW'(k), 16'h1000 + 16'(k));
    for (int k = 0; k < N; k++) read_address_bus[k*AW +: AW] = AW'(k);
    read_strobe_bus = '1;
    for (int g = 0; g < 8; g++) begin
      exp_ch = g % N;
      fv  = '0;
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
        tick();
        if (read_finished_strobe_bus != '0) begin
          fv  = read_finished_strobe_bus;
          lat = i;
          break;
        end
      end
      checks++; if (fv !== (4'b0001 << exp_ch)) begin errors++; $display("FAIL rr_order grant=%0d got=%b exp=%b", g, fv, 4'b0001 << exp_ch); end
      checks++; if (read_data !== (16'h1000 + 16'(exp_ch))) begin errors++; $display("FAIL rr_data grant=%0d got=%h exp=%h", g, read_data, 16'h1000 + 16'(exp_ch)); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL rr_gap grant=%0d got=%0d exp=3", g, lat); end
      $display("rr grant=%0d fin=%b data=0x%04h gap=%0d", g, fv, read_data, lat);
    end
    read_strobe_bus = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_boundary();
    logic [15:0]  d;
    logic [N-1:0] fv;
    int           lat;
    do_write(12'd0, 16'h0123);
    do_write(12'd1343, 16'hFEDC);
    do_read(0, 12'd0, d, fv, lat);
    checks++; if (d !== 16'h0123) begin errors++; $display("FAIL bnd_addr0 got=%h exp=0123", d); end
    checks++; if (fv !== 4'b0001 || lat !== 3) begin errors++; $display("FAIL bnd_addr0_fin got=%b/%0d exp=0001/3", fv, lat); end
    do_read(3, 12'd1343, d, fv, lat);
    checks++; if (d !== 16'hFEDC) begin errors++; $display("FAIL bnd_addr1343 got=%h exp=fedc", d); end
    checks++; if (fv !== 4'b1000 || lat !== 3) begin errors++; $display("FAIL bnd_addr1343_fin got=%b/%0d exp=1000/3", fv, lat); end
    checks++; if (addr_error !== 1'b0) begin errors++; $display("FAIL bnd_no_error got=%b exp=0", addr_error); end
  endtask

  task automatic test_out_of_range();
    logic [15:0]  d;
    logic [N-1:0] fv;
    int           lat;
    do_read(3, 12'd1344, d, fv, lat);
    checks++; if (fv !== 4'b1000 || lat !== 3) begin errors++; $display("FAIL oor_fin got=%b/%0d exp=1000/3", fv, lat); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL oor_data got=%h exp=0000", d); end
    checks++; if (addr_error !== 1'b1) begin errors++; $display("FAIL oor_error got=%b exp=1", addr_error); end
    tick();
    tick();
    tick();
    checks++; if (addr_error !== 1'b1) begin errors++; $display("FAIL oor_error_sticky got=%b exp=1", addr_error); end
    do_read(1, 12'd5, d, fv, lat);
    checks++; if (d !== 16'hA5C3 || fv !== 4'b0010) begin errors++; $display("FAIL oor_then_good got=%h/%b exp=a5c3/0010", d, fv); end
    checks++; if (addr_error !== 1'b1) begin errors++; $display("FAIL oor_error_sticky2 got=%b exp=1", addr_error); end
  endtask

  task automatic test_reset_mid_read();
    logic [N-1:0] fv;
    int           lat;
    do_write(12'd7, 16'h7777);
    read_address_bus[1*AW +: AW] = 12'd7;
    read_strobe_bus[1] = 1'b1;
    tick();                 // grant taken; DUT now in READ_ISSUE
    rst = 1'b1;
    tick();
    checks++; if (read_finished_strobe_bus !== 4'b0) begin errors++; $display("FAIL rmr_fin got=%b exp=0000", read_finished_strobe_bus); end
    checks++; if (read_data !== 16'h0) begin errors++; $display("FAIL rmr_read_data got=%h exp=0000", read_data); end
    checks++; if (write_ready !== 1'b1) begin errors++; $display("FAIL rmr_write_ready got=%b exp=1", write_ready); end
    checks++; if (addr_error !== 1'b0) begin errors++; $display("FAIL rmr_addr_error got=%b exp=0", addr_error); end
    tick();
    checks++; if (read_finished_strobe_bus !== 4'b0) begin errors++; $display("FAIL rmr_fin2 got=%b exp=0000", read_finished_strobe_bus); end
    rst = 1'b0;
    fv  = '0;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (read_finished_strobe_bus != '0) begin
        fv  = read_finished_strobe_bus;
        lat = i;
        break;
      end
    end
    checks++; if (fv !== 4'b0010 || lat !== 3) begin errors++; $display("FAIL rmr_reservice got=%b/%0d exp=0010/3", fv, lat); end
    checks++; if (read_data !== 16'h7777) begin errors++; $display("FAIL rmr_data got=%h exp=7777", read_data); end
    read_strobe_bus[1] = 1'b0;
    tick();
    tick();
    $display("reset mid-read: reserviced fin=%b data=0x%04h", fv, read_data);
  endtask

  task automatic test_write_read_collision();
    logic [15:0]  d;
    logic [N-1:0] fv;
    int           lat;
    do_write(12'd20, 16'h2222);
    do_write(12'd21, 16'h2121);
    read_address_bus[2*AW +: AW] = 12'd20;
    read_strobe_bus[2] = 1'b1;
    write_address = 12'd20;
    write_data    = 16'hBEEF;
    write_strobe  = 1'b1;
    tick();
    checks++; if (write_ready !== 1'b0) begin errors++; $display("FAIL col_ready_low got=%b exp=0", write_ready); end
    checks++; if (addr_error !== 1'b0) begin errors++; $display("FAIL col_err_before got=%b exp=0", addr_error); end
    write_address = 12'd21;   // second write while not ready: must be dropped
    write_data    = 16'h5555;
    tick();
    write_strobe  = 1'b0;
    checks++; if (addr_error !== 1'b1) begin errors++; $display("FAIL col_drop_error got=%b exp=1", addr_error); end
    tick();
    checks++; if (read_finished_strobe_bus !== 4'b0100) begin errors++; $display("FAIL col_fin_ch2 got=%b exp=0100", read_finished_strobe_bus); end
    checks++; if (read_data !== 16'h2222) begin errors++; $display("FAIL col_read_first got=%h exp=2222", read_data); end
    checks++; if (write_ready !== 1'b0) begin errors++; $display("FAIL col_ready_still_low got=%b exp=0", write_ready); end
    read_strobe_bus[2] = 1'b0;
    tick();
    checks++; if (write_ready !== 1'b0) begin errors++; $display("FAIL col_ready_in_write got=%b exp=0", write_ready); end
    tick();
    checks++; if (write_ready !== 1'b1) begin errors++; $display("FAIL col_ready_after got=%b exp=1", write_ready); end
    $display("collision: read ch2 addr=20 returned 0x2222 before write");
    do_read(1, 12'd20, d, fv, lat);
    checks++; if (d !== 16'hBEEF || fv !== 4'b0010) begin errors++; $display("FAIL col_write_landed got=%h/%b exp=beef/0010", d, fv); end
    do_read(1, 12'd21, d, fv, lat);
    checks++; if (d !== 16'h2121) begin errors++; $display("FAIL col_dropped_write got=%h exp=2121", d); end
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    rst              = 1'b1;
    read_address_bus = '0;
    read_strobe_bus  = '0;
    write_address    = '0;
    write_data       = '0;
    write_strobe     = 1'b0;

    test_reset();
    test_write_read();
    test_round_robin();
    test_boundary();
    test_out_of_range();
    test_reset_mid_read();
    test_write_read_collision();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
